// File: rtl/width_converter_mton.sv
// Packs a stream of InWidth-bit beats into OutWidth-bit words, lane 0 first.
// Two stages: an assembly register (p0) feeding an output holding register (p1).
module width_converter_mton #(
  parameter int InWidth  = 8,
  parameter int OutWidth = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [InWidth-1:0]                           in_data_i,
  input  logic                                         in_flush_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [OutWidth-1:0]                          out_data_o,
  output logic [$clog2(OutWidth/InWidth+1)-1:0]        out_lanes_o,
  output logic                                         out_flushed_o
);

  localparam int Lanes = OutWidth / InWidth;
  localparam int LW    = $clog2(Lanes + 1);
  localparam logic [LW-1:0] LanesC = LW'(Lanes);

  if (InWidth < 1 || (OutWidth % InWidth) != 0 || Lanes < 2) begin : g_bad_params
    $error("width_converter_mton: OutWidth must be a multiple of InWidth with ratio >= 2");
  end

  logic [OutWidth-1:0] asm_data_p0;
  logic [LW-1:0]       acnt_p0;
  logic                flush_pend_p0;

  logic [OutWidth-1:0] hold_data_p1;
  logic [LW-1:0]       hold_lanes_p1;
  logic                hold_flushed_p1;
  logic                vld_p1;

  logic                full;
  logic                nonempty;
  logic                free;
  logic                commit;
  logic                accept;
  logic                pop;
  logic [OutWidth-1:0] asm_ins;

  assign full       = (acnt_p0 == LanesC);
  assign nonempty   = (acnt_p0 != '0);
  assign free       = !vld_p1 || out_ready_i;
  assign commit     = free && (full || (flush_pend_p0 && nonempty));
  assign in_ready_o = commit || (!flush_pend_p0 && !full);
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = vld_p1 && out_ready_i;

  // Assembly register with the incoming beat dropped into lane acnt.
  always_comb begin
    asm_ins = asm_data_p0;
    for (int k = 0; k < Lanes; k++) begin
      if (acnt_p0 == LW'(k)) asm_ins[k*InWidth +: InWidth] = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_data_p0     <= '0;
      acnt_p0         <= '0;
      flush_pend_p0   <= 1'b0;
      hold_data_p1    <= '0;
      hold_lanes_p1   <= '0;
      hold_flushed_p1 <= 1'b0;
      vld_p1          <= 1'b0;
    end else if (commit) begin
      // p0 -> p1: move the finished word out; a same-cycle beat opens the next one.
      hold_data_p1    <= asm_data_p0;
      hold_lanes_p1   <= acnt_p0;
      hold_flushed_p1 <= flush_pend_p0;
      vld_p1          <= 1'b1;
      asm_data_p0     <= accept ? OutWidth'(in_data_i) : '0;
      acnt_p0         <= accept ? LW'(1) : '0;
      flush_pend_p0   <= accept && in_flush_i;
    end else begin
      if (pop) begin
        hold_data_p1    <= '0;
        hold_lanes_p1   <= '0;
        hold_flushed_p1 <= 1'b0;
        vld_p1          <= 1'b0;
      end
      if (accept) begin
        asm_data_p0 <= asm_ins;
        acnt_p0     <= acnt_p0 + LW'(1);
      end
      // A flush on an empty assembler with no beat has nothing to close.
      if (in_flush_i && (nonempty || accept)) flush_pend_p0 <= 1'b1;
    end
  end

  assign out_valid_o   = vld_p1;
  assign out_data_o    = hold_data_p1;
  assign out_lanes_o   = hold_lanes_p1;
  assign out_flushed_o = hold_flushed_p1;

endmodule
